bstep_act_scheduler: RTL

Shares one 5-bit binary-step activation evaluator among `N_REQ` neuron requesters. A round-robin arbiter grants one requester per cycle and evaluates its pre-activation in exact or approximate mode. The block queues the 1-bit result with the requester id in a 2-entry output buffer. It sits between the neuron accumulators and the downstream spike/activation collector, and also sequences safe switching between exact and approximate modes.

---
 rtl/bstep_act_scheduler_if.sv | 40 ++++
 rtl/bstep_act_scheduler.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bstep_act_scheduler_if.sv
// Handshake bundle between the neuron requesters, the shared activation
// scheduler and the downstream activation collector.
interface bstep_act_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 5
);
    // Requester side: one valid/ready pair and one data slice per requester
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    // Result side: head of the result buffer
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_act;
    logic [ID_W-1:0]         out_id;

    // Requesters and collector (environment side)
    modport master (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_act,
        input  out_id
    );

    // Scheduler side
    modport slave (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_act,
        output out_id
    );
endinterface

// File: rtl/bstep_act_scheduler.sv
// Shared 5-bit binary-step activation evaluator with a round-robin arbiter,
// a 2-entry {act, id} result buffer and drain-then-switch mode sequencing.
module bstep_act_scheduler #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_req,
    output logic                 mode_cur,
    output logic                 busy,
    bstep_act_scheduler_if.slave bus
);

    // Arbiter and evaluator state
    logic [ID_W-1:0]   ptr_reg;
    logic              mode_cur_reg;

    // Result buffer: two slots addressed by 1-bit read/write pointers
    logic              act_mem_reg [2];
    logic [ID_W-1:0]   id_mem_reg  [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic [1:0]        count_next;

    // Per-requester data slices
    logic [DATA_W-1:0] data_arr [N_REQ];

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              out_valid_int;
    logic              pop;
    logic              can_accept;
    logic              mode_match;
    logic              push;
    logic [DATA_W-1:0] sel_data;
    logic              act_new;
    logic [N_REQ-1:0]  ready_vec;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign out_valid_int = (count_reg != 2'd0);
    assign pop           = out_valid_int & bus.out_ready;
    // A full buffer still accepts when its head leaves in the same cycle
    assign can_accept    = (count_reg != 2'd2) | pop;
    assign mode_match    = (mode_req == mode_cur_reg);
    // Grants stop while a mode change is pending and while reset is held
    assign push          = grant_found & can_accept & mode_match & ~rst;

    // Round-robin scan: first valid requester starting at ptr, wrapping around
    always_comb begin
        logic [ID_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr_reg + ID_W'(k);
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // One-hot grant to the selected requester only when the transfer can happen
    always_comb begin
        ready_vec = '0;
        if (push) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    // Evaluate the granted pre-activation with the currently applied mode
    always_comb begin
        sel_data = data_arr[grant_idx];
        if (mode_cur_reg) begin
            act_new = ~sel_data[0];
        end else begin
            act_new = ~sel_data[DATA_W-1];
        end
    end

    // Buffer occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Result buffer, arbiter pointer and applied mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                act_mem_reg[i] <= 1'b0;
                id_mem_reg[i]  <= '0;
            end
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            ptr_reg      <= '0;
            mode_cur_reg <= 1'b0;
        end else begin
            if (push) begin
                act_mem_reg[wr_ptr_reg] <= act_new;
                id_mem_reg[wr_ptr_reg]  <= grant_idx;
                wr_ptr_reg              <= ~wr_ptr_reg;
                ptr_reg                 <= grant_idx + ID_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
            // Mode only changes once every old-mode result has drained
            if (!mode_match && (count_reg == 2'd0)) begin
                mode_cur_reg <= mode_req;
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.out_valid = out_valid_int;
    assign bus.out_act   = act_mem_reg[rd_ptr_reg];
    assign bus.out_id    = id_mem_reg[rd_ptr_reg];
    assign mode_cur      = mode_cur_reg;
    assign busy          = out_valid_int | ~mode_match;

endmodule
